alu_pipe: RTL and testbench

Two-stage elastic execute pipeline around the 32-bit `alu`. It accepts operand/opcode tokens from decode over a valid/ready handshake, registers them, and evaluates them through an `alu` instance. It registers Result and flags toward writeback over a second valid/ready handshake. It also keeps a sticky signed-overflow status bit and a completed-operation counter for the CPU status path.

---
 rtl/alu_pkg.sv | 20 ++
 rtl/alu.sv | 56 +++++
 rtl/alu_pipe.sv | 133 +++++++++++++
 tb/tb_alu_pipe.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width, opcode encodings and opcode helpers.
// Used by the ALU itself, the execute pipe and decode.
package alu_pkg;

  localparam int DATA_WIDTH = 32;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_e;

  // Only true arithmetic results are allowed to raise the sticky overflow status.
  function automatic logic is_add_sub(input logic [2:0] op);
    return (op == ALU_ADD) || (op == ALU_SUB);
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU: AND/OR/ADD/SUB/SLT with Zero, signed Overflow and CarryOut.
// SUB and SLT report CarryOut as the unsigned borrow (A < B).
module alu
  import alu_pkg::*;
#(
  parameter int W = DATA_WIDTH
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic [2:0]   i_alu_op,
  output logic [W-1:0] o_result,
  output logic         o_zero,
  output logic         o_overflow,
  output logic         o_carry_out
);

  logic [W:0] w_sum;
  logic [W:0] w_diff;
  logic       w_add_ovf;
  logic       w_sub_ovf;

  assign w_sum     = {1'b0, i_a} + {1'b0, i_b};
  assign w_diff    = {1'b0, i_a} - {1'b0, i_b};
  assign w_add_ovf = (i_a[W-1] == i_b[W-1]) && (w_sum[W-1] != i_a[W-1]);
  assign w_sub_ovf = (i_a[W-1] != i_b[W-1]) && (w_diff[W-1] != i_a[W-1]);

  always_comb begin
    o_result    = '0;
    o_overflow  = 1'b0;
    o_carry_out = 1'b0;
    case (i_alu_op)
      ALU_AND: o_result = i_a & i_b;
      ALU_OR:  o_result = i_a | i_b;
      ALU_ADD: begin
        o_result    = w_sum[W-1:0];
        o_overflow  = w_add_ovf;
        o_carry_out = w_sum[W];
      end
      ALU_SUB: begin
        o_result    = w_diff[W-1:0];
        o_overflow  = w_sub_ovf;
        o_carry_out = w_diff[W];
      end
      // Signed compare: sign of the true difference is diff MSB corrected by overflow.
      ALU_SLT: begin
        o_result    = {{(W-1){1'b0}}, w_diff[W-1] ^ w_sub_ovf};
        o_overflow  = w_sub_ovf;
        o_carry_out = w_diff[W];
      end
      default: ;
    endcase
  end

  assign o_zero = (o_result == '0);

endmodule

// File: rtl/alu_pipe.sv
// Two-stage elastic execute pipe around the ALU: operand register (S1) feeding result
// register (S2), with sticky signed-overflow status and a completed-operation counter.
module alu_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_W      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_A,
  input  logic [DATA_WIDTH-1:0] in_B,
  input  logic [2:0]            in_ALUop,
  input  logic [TAG_W-1:0]      in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_Result,
  output logic                  out_Zero,
  output logic                  out_Overflow,
  output logic                  out_CarryOut,
  output logic [TAG_W-1:0]      out_tag,
  input  logic                  sticky_clr,
  output logic                  sticky_ovf,
  output logic [31:0]           op_count
);
  import alu_pkg::*;

  logic                  r_s1_valid;
  logic [DATA_WIDTH-1:0] r_s1_a;
  logic [DATA_WIDTH-1:0] r_s1_b;
  logic [2:0]            r_s1_op;
  logic [TAG_W-1:0]      r_s1_tag;

  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_result;
  logic                  r_out_zero;
  logic                  r_out_ovf;
  logic                  r_out_carry;
  logic [TAG_W-1:0]      r_out_tag;
  logic                  r_sticky;
  logic [31:0]           r_op_count;

  logic [DATA_WIDTH-1:0] w_alu_result;
  logic                  w_alu_zero;
  logic                  w_alu_ovf;
  logic                  w_alu_carry;
  logic                  w_s2_free;
  logic                  w_s1_load;
  logic                  w_s2_load;
  logic                  w_out_fire;

  // No skid buffer: in_ready looks straight through to out_ready.
  assign w_s2_free  = !r_out_valid || out_ready;
  assign in_ready   = !r_s1_valid || w_s2_free;
  assign w_s1_load  = in_valid && in_ready;
  assign w_s2_load  = r_s1_valid && w_s2_free;
  assign w_out_fire = r_out_valid && out_ready;

  alu #(.W(DATA_WIDTH)) u_alu (
    .i_a         (r_s1_a),
    .i_b         (r_s1_b),
    .i_alu_op    (r_s1_op),
    .o_result    (w_alu_result),
    .o_zero      (w_alu_zero),
    .o_overflow  (w_alu_ovf),
    .o_carry_out (w_alu_carry)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_op    <= '0;
      r_s1_tag   <= '0;
    end else if (w_s1_load) begin
      r_s1_valid <= 1'b1;
      r_s1_a     <= in_A;
      r_s1_b     <= in_B;
      r_s1_op    <= in_ALUop;
      r_s1_tag   <= in_tag;
    end else if (w_s2_load) begin
      r_s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
      r_out_zero   <= 1'b0;
      r_out_ovf    <= 1'b0;
      r_out_carry  <= 1'b0;
      r_out_tag    <= '0;
    end else if (w_s2_load) begin
      r_out_valid  <= 1'b1;
      r_out_result <= w_alu_result;
      r_out_zero   <= w_alu_zero;
      r_out_ovf    <= w_alu_ovf;
      r_out_carry  <= w_alu_carry;
      r_out_tag    <= r_s1_tag;
    end else if (out_ready) begin
      r_out_valid  <= 1'b0;
    end
  end

  // A set on the same edge as a clear takes priority so no overflow event is lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sticky   <= 1'b0;
      r_op_count <= '0;
    end else begin
      if (w_s2_load && w_alu_ovf && is_add_sub(r_s1_op)) begin
        r_sticky <= 1'b1;
      end else if (sticky_clr) begin
        r_sticky <= 1'b0;
      end
      if (w_out_fire) begin
        r_op_count <= r_op_count + 32'd1;
      end
    end
  end

  assign out_valid    = r_out_valid;
  assign out_Result   = r_out_result;
  assign out_Zero     = r_out_zero;
  assign out_Overflow = r_out_ovf;
  assign out_CarryOut = r_out_carry;
  assign out_tag      = r_out_tag;
  assign sticky_ovf   = r_sticky;
  assign op_count     = r_op_count;

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: directed vector table, hand-written handshake/reset sequences,
// then random traffic checked against an arithmetic reference model and a token queue.
module tb_alu_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_A = '0;
  logic [31:0] in_B = '0;
  logic [2:0]  in_ALUop = '0;
  logic [3:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_Result;
  logic        out_Zero;
  logic        out_Overflow;
  logic        out_CarryOut;
  logic [3:0]  out_tag;
  logic        sticky_clr = 1'b0;
  logic        sticky_ovf;
  logic [31:0] op_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_pipe #(.DATA_WIDTH(32), .TAG_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_A(in_A), .in_B(in_B), .in_ALUop(in_ALUop), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_Result(out_Result), .out_Zero(out_Zero),
    .out_Overflow(out_Overflow), .out_CarryOut(out_CarryOut), .out_tag(out_tag),
    .sticky_clr(sticky_clr), .sticky_ovf(sticky_ovf), .op_count(op_count)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                       input logic [3:0] tag);
    in_valid = 1'b1;
    in_A     = a;
    in_B     = b;
    in_ALUop = op;
    in_tag   = tag;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; sticky_clr = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Reference ALU from plain signed/unsigned arithmetic.
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;
  localparam longint UMAX = 64'sd4294967295;

  function automatic void ref_alu(input logic [31:0] a, input logic [31:0] b,
                                  input logic [2:0] op, output logic [31:0] r,
                                  output logic z, output logic v, output logic c);
    longint sa, sb, ua, ub, t;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ua = longint'(a);          ub = longint'(b);
    r = '0; v = 1'b0; c = 1'b0; t = 0;
    case (op)
      3'b000: r = a & b;
      3'b001: r = a | b;
      3'b010: begin t = sa + sb; r = t[31:0]; v = (t > SMAX) || (t < SMIN); c = (ua + ub) > UMAX; end
      3'b110: begin t = sa - sb; r = t[31:0]; v = (t > SMAX) || (t < SMIN); c = (ua < ub); end
      3'b111: r = (sa < sb) ? 32'd1 : 32'd0;
      default: r = '0;
    endcase
    z = (r == 32'd0);
  endfunction

  function automatic logic arith(input logic [2:0] op);
    return (op == 3'b010) || (op == 3'b110);
  endfunction

  typedef struct {
    logic [31:0] a, b;
    logic [2:0]  op;
    logic [3:0]  tag;
    logic [31:0] res;
    logic        z, v, c, flags, sticky;
  } vec_t;

  typedef struct {
    logic [2:0]  op;
    logic [3:0]  tag;
    logic [31:0] res;
    logic        z, v, c;
    int          age;
    bit          shown;
  } tok_t;

  tok_t        q[$];
  logic        m_sticky;
  logic [31:0] m_count;

  // Pipe as a capacity-2 FIFO: a token is deliverable once it has spent one edge inside.
  function automatic void model_step(input bit v_in, input bit rdy, input bit clr, input tok_t t);
    bit fire_out, fire_in, set;
    fire_out = (q.size() > 0) && (q[0].age >= 1) && rdy;
    fire_in  = v_in && ((q.size() < 2) || rdy);
    if (fire_out) begin
      $display("txn tag=%0h op=%03b res=%08h z=%0b v=%0b c=%0b", q[0].tag, q[0].op, q[0].res,
               q[0].z, q[0].v, q[0].c);
      void'(q.pop_front());
      m_count = m_count + 32'd1;
    end
    for (int i = 0; i < q.size(); i++) q[i].age = q[i].age + 1;
    if (fire_in) q.push_back(t);
    set = 1'b0;
    if ((q.size() > 0) && (q[0].age >= 1) && !q[0].shown) begin
      q[0].shown = 1'b1;
      set = arith(q[0].op) && q[0].v;
    end
    m_sticky = set ? 1'b1 : (clr ? 1'b0 : m_sticky);
  endfunction

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 5))
      0: return 32'h7FFF_FFFF;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 3));
      default: return $urandom();
    endcase
  endfunction

  vec_t vecs[11];

  initial begin
    bit          p_valid, p_ready, p_clr, vis;
    tok_t        p_tok;
    logic [31:0] r;
    logic        z, v, c;

    vecs[0]  = '{32'h7FFF_FFFF, 32'h1,         3'b010, 4'd3,  32'h8000_0000, 0, 1, 0, 1, 1};
    vecs[1]  = '{32'd5,         32'd5,         3'b110, 4'd4,  32'h0,         1, 0, 0, 1, 1};
    vecs[2]  = '{32'd3,         32'd5,         3'b110, 4'd5,  32'hFFFF_FFFE, 0, 0, 1, 1, 1};
    vecs[3]  = '{32'h8000_0000, 32'h1,         3'b111, 4'd6,  32'h1,         0, 0, 0, 0, 1};
    vecs[4]  = '{32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'b000, 4'd7,  32'h00F0_00F0, 0, 0, 0, 0, 1};
    vecs[5]  = '{32'h1234_0000, 32'h0000_5678, 3'b001, 4'd8,  32'h1234_5678, 0, 0, 0, 0, 1};
    vecs[6]  = '{32'hFFFF_FFFF, 32'h1,         3'b011, 4'd9,  32'h0,         1, 0, 0, 0, 1};
    vecs[7]  = '{32'hFFFF_FFFF, 32'h1,         3'b010, 4'd10, 32'h0,         1, 0, 1, 1, 1};
    vecs[8]  = '{32'h8000_0000, 32'h1,         3'b110, 4'd11, 32'h7FFF_FFFF, 0, 1, 0, 1, 1};
    vecs[9]  = '{32'h5,         32'h6,         3'b100, 4'd12, 32'h0,         1, 0, 0, 0, 1};
    vecs[10] = '{32'h5,         32'h6,         3'b101, 4'd13, 32'h0,         1, 0, 0, 0, 1};

    // Reset state
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", out_Result, 0);
    chk("rst_flags", {out_Zero, out_Overflow, out_CarryOut}, 0);
    chk("rst_tag", out_tag, 0);
    chk("rst_sticky", sticky_ovf, 0);
    chk("rst_op_count", op_count, 0);
    rst = 1'b0;

    // Directed vectors, one at a time, latency 2
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      drive(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].tag);
      #1 chk($sformatf("vec%0d_in_ready", i), in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
      chk($sformatf("vec%0d_early_valid", i), out_valid, 0);
      @(negedge clk);
      $display("vec %0d op=%03b A=%08h B=%08h -> res=%08h tag=%0h", i, vecs[i].op, vecs[i].a,
               vecs[i].b, out_Result, out_tag);
      chk($sformatf("vec%0d_valid", i), out_valid, 1);
      chk($sformatf("vec%0d_result", i), out_Result, vecs[i].res);
      chk($sformatf("vec%0d_zero", i), out_Zero, vecs[i].z);
      chk($sformatf("vec%0d_tag", i), out_tag, vecs[i].tag);
      chk($sformatf("vec%0d_sticky", i), sticky_ovf, vecs[i].sticky);
      if (vecs[i].flags) begin
        chk($sformatf("vec%0d_ovf", i), out_Overflow, vecs[i].v);
        chk($sformatf("vec%0d_carry", i), out_CarryOut, vecs[i].c);
      end
    end

    // Full throughput: 8 back-to-back operations
    do_reset();
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      if (k >= 2 && k <= 9) begin
        chk($sformatf("thr%0d_valid", k), out_valid, 1);
        chk($sformatf("thr%0d_tag", k), out_tag, 4'(k - 2));
        chk($sformatf("thr%0d_result", k), out_Result, 32'(k - 2) + 32'd100);
      end else begin
        chk($sformatf("thr%0d_idle", k), out_valid, 0);
      end
      if (k < 8) drive(32'(k), 32'd100, 3'b010, 4'(k));
      else in_valid = 1'b0;
      #1 chk($sformatf("thr%0d_in_ready", k), in_ready, 1);
    end
    chk("thr_op_count", op_count, 8);

    // Backpressure: two absorbed, third refused, outputs frozen, ordered drain
    out_ready = 1'b0;
    @(negedge clk);
    drive(32'd10, 32'd1, 3'b010, 4'd1);
    #1 chk("bp_in_ready1", in_ready, 1);
    @(negedge clk);
    drive(32'd20, 32'd2, 3'b010, 4'd2);
    #1 chk("bp_in_ready2", in_ready, 1);
    @(negedge clk);
    chk("bp_valid", out_valid, 1);
    drive(32'd30, 32'd3, 3'b010, 4'd3);
    #1 chk("bp_in_ready_full", in_ready, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("bp_hold%0d_tag", k), out_tag, 1);
      chk($sformatf("bp_hold%0d_result", k), out_Result, 11);
      chk($sformatf("bp_hold%0d_valid", k), out_valid, 1);
      if (k == 2) out_ready = 1'b1;
      #1 chk($sformatf("bp_hold%0d_in_ready", k), in_ready, (k == 2));
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_drain2_tag", out_tag, 2);
    chk("bp_drain2_result", out_Result, 22);
    @(negedge clk);
    chk("bp_drain3_tag", out_tag, 3);
    chk("bp_drain3_result", out_Result, 33);
    @(negedge clk);
    chk("bp_drained", out_valid, 0);
    chk("bp_op_count", op_count, 11);

    // Clear/set collision
    sticky_clr = 1'b1;
    @(negedge clk);
    sticky_clr = 1'b0;
    chk("clr_initial", sticky_ovf, 0);
    drive(32'h7FFF_FFFF, 32'h7FFF_FFFF, 3'b010, 4'd5);
    @(negedge clk);
    in_valid = 1'b0;
    sticky_clr = 1'b1;
    @(negedge clk);
    chk("col_valid", out_valid, 1);
    chk("col_sticky_set_wins", sticky_ovf, 1);
    @(negedge clk);
    sticky_clr = 1'b0;
    chk("col_sticky_cleared", sticky_ovf, 0);

    // Asynchronous reset with two operations in flight
    out_ready = 1'b0;
    @(negedge clk);
    drive(32'h7FFF_FFFF, 32'h1, 3'b010, 4'd1);
    @(negedge clk);
    drive(32'h7FFF_FFFF, 32'h1, 3'b010, 4'd2);
    @(negedge clk);
    in_valid = 1'b0;
    chk("ar_pre_valid", out_valid, 1);
    chk("ar_pre_sticky", sticky_ovf, 1);
    chk("ar_pre_count", op_count, 12);
    #2 rst = 1'b1;
    #1;
    chk("ar_out_valid", out_valid, 0);
    chk("ar_sticky", sticky_ovf, 0);
    chk("ar_op_count", op_count, 0);
    chk("ar_in_ready", in_ready, 1);
    chk("ar_result", out_Result, 0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    drive(32'd1, 32'd2, 3'b010, 4'd9);
    @(negedge clk);
    in_valid = 1'b0;
    chk("ar_post_early", out_valid, 0);
    @(negedge clk);
    chk("ar_post_valid", out_valid, 1);
    chk("ar_post_tag", out_tag, 9);
    chk("ar_post_result", out_Result, 3);

    // Random traffic against the reference model
    do_reset();
    q.delete();
    m_sticky = 1'b0;
    m_count  = '0;
    p_valid = 0; p_ready = 1; p_clr = 0;
    p_tok = '{default: '0};
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      if (cyc > 0) model_step(p_valid, p_ready, p_clr, p_tok);
      vis = (q.size() > 0) && (q[0].age >= 1);
      chk("rnd_out_valid", out_valid, vis);
      if (vis) begin
        chk("rnd_result", out_Result, q[0].res);
        chk("rnd_zero", out_Zero, q[0].z);
        chk("rnd_tag", out_tag, q[0].tag);
        if (arith(q[0].op)) begin
          chk("rnd_ovf", out_Overflow, q[0].v);
          chk("rnd_carry", out_CarryOut, q[0].c);
        end
      end
      chk("rnd_sticky", sticky_ovf, m_sticky);
      chk("rnd_op_count", op_count, m_count);
      p_valid = ($urandom_range(0, 3) != 0);
      p_ready = ($urandom_range(0, 3) != 0);
      p_clr   = ($urandom_range(0, 15) == 0);
      p_tok.op  = 3'($urandom_range(0, 7));
      p_tok.tag = 4'(cyc);
      in_A = rnd_opnd();
      in_B = ($urandom_range(0, 7) == 0) ? in_A : rnd_opnd();
      ref_alu(in_A, in_B, p_tok.op, r, z, v, c);
      p_tok.res = r; p_tok.z = z; p_tok.v = v; p_tok.c = c;
      p_tok.age = 0; p_tok.shown = 1'b0;
      in_valid   = p_valid;
      in_ALUop   = p_tok.op;
      in_tag     = p_tok.tag;
      out_ready  = p_ready;
      sticky_clr = p_clr;
      #1 chk("rnd_in_ready", in_ready, (q.size() < 2) || p_ready);
    end
    in_valid   = 1'b0;
    sticky_clr = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
